// File: rtl/alu_acc_seq.sv
// alu_acc_seq: registered accumulator ALU with a multi-cycle shift-add multiply.
// Operand A is Data; operand B is the low half of the output register.
// Optional feature: define ALU_ACC_OVF_EN to add the registered Overflow output.
module alu_acc_seq #(
    parameter int WIDTH      = 4,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic               Clock,
    input  logic               Reset_b,
    input  logic [WIDTH-1:0]   Data,
    input  logic [2:0]         Function,
    input  logic               Enable,
    output logic [2*WIDTH-1:0] ALUout,
    output logic               Busy,
    output logic               Done
`ifdef ALU_ACC_OVF_EN
    ,
    output logic               Overflow
`endif
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     b;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   op_result;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 op_accept;
    logic                 mul_last;

    assign b = ALUout[WIDTH-1:0];

    // Single-cycle result for the selected function (111 and 110 keep the register value)
    always_comb begin
        sum       = {1'b0, Data} + {1'b0, b};
        diff      = {1'b0, Data} - {1'b0, b};
        op_result = ALUout;
        case (Function)
            3'b000:  op_result = {{(WIDTH-1){1'b0}}, sum};
            3'b001:  op_result = {{(WIDTH-1){diff[WIDTH]}}, diff};
            3'b010:  op_result = {{WIDTH{b[WIDTH-1]}}, b};
            3'b011:  op_result = {{(2*WIDTH-1){1'b0}}, |{Data, b}};
            3'b100:  op_result = {{(2*WIDTH-1){1'b0}}, &{Data, b}};
            3'b101:  op_result = {Data, b};
            default: op_result = ALUout;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next  = mplier[0] ? acc + mcand : acc;
        op_accept = (state == S_IDLE) && Enable && (Function != 3'b110);
        mul_last  = (state == S_MUL) && (cnt == LAST_ITER);
    end

    // Control FSM, result register and multiplier datapath
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state  <= S_IDLE;
            ALUout <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Enable) begin
                        if (Function == 3'b110) begin
                            mcand  <= {{WIDTH{1'b0}}, Data};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            Busy   <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            ALUout <= op_result;
                            Done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        ALUout <= acc_next;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ACC_OVF_EN
    logic op_ovf;

    // Overflow flag for the single-cycle op: carry for add, signed overflow for subtract
    always_comb begin
        op_ovf = 1'b0;
        case (Function)
            3'b000:  op_ovf = sum[WIDTH];
            3'b001:  op_ovf = (Data[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != Data[WIDTH-1]);
            default: op_ovf = 1'b0;
        endcase
    end

    // Overflow register follows every completed op, multiply always clears it
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            Overflow <= 1'b0;
        end else if (op_accept) begin
            Overflow <= op_ovf;
        end else if (mul_last) begin
            Overflow <= 1'b0;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = op_accept ^ mul_last;
`endif

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- Operand A comes from the `Data` input. Operand B is fed back from the low half of the output register, so the block works as an accumulator.
- Adds a multi-cycle unsigned shift-add multiply with a Busy/Done handshake.
- Sits between switch/datapath inputs and the hex display decoders.

Parameters:
- WIDTH, 4: operand width W. Output register is 2W bits.
- MUL_CYCLES, WIDTH: iterations of the shift-add multiply. Must equal WIDTH; the other value is not supported.

Ports:
- Clock  in  1  rising-edge clock
- Reset_b  in  1  asynchronous active-low reset
- Data  in  WIDTH  operand A
- Function  in  3  operation select
- Enable  in  1  start request, sampled on rising edge
- ALUout  out  2*WIDTH  registered result; B = ALUout[WIDTH-1:0]
- Busy  out  1  multiply in progress
- Done  out  1  one-cycle completion pulse

Behaviour:
- Reset_b=0, asynchronous: ALUout=0, Busy=0, Done=0, FSM to IDLE, multiplier regs cleared.
- Reset asserted mid-multiply aborts the operation with no Done pulse.
- FSM states:
  - IDLE: Enable=1 and Function!=110 → execute, stay IDLE. Enable=1 and Function=110 → MUL.
  - MUL: counts MUL_CYCLES iterations → IDLE.
- Single-cycle ops, latency 1:
  - Enable sampled high at edge N → ALUout updates at edge N.
  - Done=1 for the cycle after edge N only.
- Operations, with A=Data and B=ALUout[W-1:0]:
  - 000: A+B unsigned, W+1 bits, zero-extended to 2W.
  - 001: A−B two's complement, computed W+1 bits, sign-extended to 2W.
  - 010: B sign-extended to 2W.
  - 011: 1 if any bit of A or B is 1, else 0.
  - 100: 1 if all bits of {A,B} are 1, else 0.
  - 101: {A,B}.
  - 110: A*B unsigned, 2W-bit result, multi-cycle.
  - 111: hold ALUout unchanged; Done still pulses.
- Multiply:
  - At start edge N: latch A and B into internal regs and set Busy=1. ALUout does not change during MUL.
  - Edges N+1..N+W: one shift-add iteration per edge.
  - Edge N+W: ALUout=product, Busy=0, Done=1 for one cycle.
- Enable while Busy=1 is ignored, including changes to Data/Function. Multiply uses only the latched operands.
- Enable=0 in IDLE: ALUout holds, Done=0.
- Back-to-back ops:
  - Enable held high issues one op per clock in IDLE, each seeing the previous result as B.
  - After a multiply, the next start is accepted on the first edge with Busy=0.
- Arithmetic wraps modulo 2^(2W); no saturation.

Optional Feature:
- Macro ALU_ACC_OVF_EN.
- Defined: adds output port Overflow (1 bit), registered and updated with ALUout on every completed op.
  - 000: Overflow = carry out of bit W−1.
  - 001: Overflow = signed W-bit overflow, i.e. A,B signs differ and result sign ≠ A sign.
  - All other functions: Overflow=0.
  - Reset value 0.
- Undefined: Overflow port and logic absent; all other behaviour identical.

Test Plan (WIDTH=4):
- Reset: pulse Reset_b=0 asynchronously, mid-cycle → ALUout=8'h00, Busy=0, Done=0 immediately, without a clock edge.
- Accumulate:
  - From reset, Data=5, Function=000, Enable 1 cycle → ALUout=8'h05, Done high exactly 1 cycle.
  - Then Data=3, Function=000 → ALUout=8'h08.
- Subtract and sign-extend:
  - ALUout=8'h03, Data=1, Function=001 → ALUout=8'hFE.
  - Then Function=010 → ALUout=8'hFE (B=4'hE sign-extended).
- Multiply:
  - ALUout=8'h07, Data=6, Function=110, Enable 1 cycle → Busy=1 for 4 cycles, ALUout stays 8'h07.
  - Then ALUout=8'h2A with Done=1 for 1 cycle.
  - Enable/Data toggled during Busy have no effect.
- Reset mid-multiply: start 4'hF*4'hF and drop Reset_b at iteration 2 → ALUout=0, Busy=0, no Done. A fresh op after release works normally.
- Reductions:
  - Data=0, ALUout=8'h00, Function=011 → 8'h00.
  - Data=4'hF, ALUout=8'h0F, Function=100 → 8'h01.
  - Data=4'hA, ALUout=8'h0B, Function=101 → 8'hAB.
  - With ALU_ACC_OVF_EN: Data=7, ALUout=8'h01, Function=000 → Overflow=0. Then Data=4'hF, B=8, Function=000 → Overflow=1.
